mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch (IF) and
// load/store (MEM) stages. It runs one request/ready/rvalid transaction at a time
// and freezes the pipeline with stall signals while an access is outstanding.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wstrb,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_done,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_ready,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q, owner_d;
    logic               discard_q, discard_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               timed_out;

    logic               m_req_d, m_we_d;
    logic [ADDR_W-1:0]  m_addr_d;
    logic [DATA_W-1:0]  m_wdata_d;
    logic [DATA_W/8-1:0] m_wstrb_d;
    logic [DATA_W-1:0]  if_rdata_d, mem_rdata_d;
    logic               if_done_d, mem_done_d, err_d;

    logic               if_live, mem_live, grant_mem, if_killed;

    // Request qualification and round-robin pick (a lone requester always wins)
    assign if_live   = if_req & ~if_kill;
    assign mem_live  = mem_rd | mem_wr;
    assign grant_mem = mem_live & (~if_live | (last_grant_q == OWN_IF));
    assign if_killed = (owner_q == OWN_IF) & if_kill;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign timed_out = (cnt_inc == CNT_W'(TIMEOUT));

    // Pipeline stalls: hold a stage until its completion pulse arrives
    assign stall_mem = (mem_rd | mem_wr) & ~mem_done;
    assign stall_if  = (if_req & ~if_done) | stall_mem;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        discard_d    = discard_q;
        cnt_d        = cnt_q;
        m_req_d      = 1'b0;
        m_we_d       = m_we;
        m_addr_d     = m_addr;
        m_wdata_d    = m_wdata;
        m_wstrb_d    = m_wstrb;
        if_rdata_d   = if_rdata;
        mem_rdata_d  = mem_rdata;
        if_done_d    = 1'b0;
        mem_done_d   = 1'b0;
        err_d        = err;

        case (state_q)
            IDLE: begin
                if (if_live | mem_live) begin
                    owner_d      = grant_mem;
                    last_grant_d = grant_mem;
                    m_we_d       = grant_mem & mem_wr;
                    m_addr_d     = grant_mem ? mem_addr : if_addr;
                    m_wdata_d    = (grant_mem & mem_wr) ? mem_wdata : '0;
                    m_wstrb_d    = (grant_mem & mem_wr) ? mem_wstrb : '1;
                    cnt_d        = '0;
                    discard_d    = 1'b0;
                    m_req_d      = 1'b1;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (if_killed) begin
                    state_d = IDLE;
                end else if (m_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_inc;
                    m_req_d = 1'b1;
                end
            end
            WAIT: begin
                if (if_killed) begin
                    discard_d = 1'b1;
                end
                if (m_rvalid) begin
                    if ((owner_q == OWN_IF) && (discard_q || if_kill)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                        if (owner_q == OWN_IF) begin
                            if_rdata_d = m_rdata;
                            if_done_d  = 1'b1;
                        end else begin
                            mem_done_d = 1'b1;
                            if (!m_we) begin
                                mem_rdata_d = m_rdata;
                            end
                        end
                    end
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= OWN_IF;
            owner_q      <= OWN_IF;
            discard_q    <= 1'b0;
            cnt_q        <= '0;
            m_req        <= 1'b0;
            m_we         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            m_wstrb      <= '0;
            if_rdata     <= '0;
            mem_rdata    <= '0;
            if_done      <= 1'b0;
            mem_done     <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            discard_q    <= discard_d;
            cnt_q        <= cnt_d;
            m_req        <= m_req_d;
            m_we         <= m_we_d;
            m_addr       <= m_addr_d;
            m_wdata      <= m_wdata_d;
            m_wstrb      <= m_wstrb_d;
            if_rdata     <= if_rdata_d;
            mem_rdata    <= mem_rdata_d;
            if_done      <= if_done_d;
            mem_done     <= mem_done_d;
            err          <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-cycle vector table, directed corner sequences,
// and randomized transactions scored against a transaction-level model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill, mem_rd, mem_wr, m_ready, m_rvalid;
    logic [31:0] if_addr, mem_addr, mem_wdata, m_rdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] if_rdata, mem_rdata, m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        if_done, mem_done, stall_if, stall_mem, m_req, m_we, err;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: last granted stage and the data each stage should hold
    logic        last_mem;
    logic [31:0] exp_if_rdata, exp_mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_done(if_done),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rvalid(m_rvalid),
        .m_rdata(m_rdata), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        if_kill;
        logic        mem_rd;
        logic        mem_wr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
        logic        m_ready;
        logic        m_rvalid;
        logic [31:0] m_rdata;
        logic        e_m_req;
        logic        e_m_we;
        logic [31:0] e_m_addr;
        logic [31:0] e_m_wdata;
        logic [3:0]  e_m_wstrb;
        logic        e_if_done;
        logic        e_mem_done;
        logic        e_stall_if;
        logic        e_stall_mem;
        logic [31:0] e_if_rdata;
        logic [31:0] e_mem_rdata;
        logic        e_err;
    } vec_t;

    localparam logic        H  = 1'b1;
    localparam logic        L  = 1'b0;
    localparam logic [31:0] Z  = 32'h0;
    localparam logic [31:0] A  = 32'h0000_0100;
    localparam logic [31:0] SA = 32'h0000_2004;
    localparam logic [31:0] SD = 32'hDEAD_BEEF;
    localparam logic [31:0] RD = 32'h0050_0093;
    localparam logic [31:0] JD = 32'h1234_5678;
    localparam logic [3:0]  S0 = 4'h0;
    localparam logic [3:0]  S3 = 4'h3;
    localparam logic [3:0]  SF = 4'hF;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        if_req = 1'b0; if_addr = 32'h0; if_kill = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = 32'h0;
        mem_wdata = 32'h0; mem_wstrb = 4'h0;
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        last_mem      = 1'b0;
        exp_if_rdata  = 32'h0;
        exp_mem_rdata = 32'h0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk1({tag, "_m_req"}, m_req, 1'b0);
        chk1({tag, "_m_we"}, m_we, 1'b0);
        chk({tag, "_m_addr"}, m_addr, 32'h0);
        chk({tag, "_m_wdata"}, m_wdata, 32'h0);
        chk({tag, "_m_wstrb"}, 32'(m_wstrb), 32'h0);
        chk({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk({tag, "_mem_rdata"}, mem_rdata, 32'h0);
        chk1({tag, "_if_done"}, if_done, 1'b0);
        chk1({tag, "_mem_done"}, mem_done, 1'b0);
        chk1({tag, "_err"}, err, 1'b0);
    endtask

    // Memory-side responder: waits for a request, inserts wait states, returns data
    task automatic serve(input logic [31:0] data, input int rdy, input int rv,
                         output int lat, output logic [31:0] a, output logic we,
                         output logic [3:0] st, output logic [31:0] wd, output logic ok);
        lat = 0;
        while (m_req !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        ok = (m_req === 1'b1);
        a = m_addr; we = m_we; st = m_wstrb; wd = m_wdata;
        if (!ok) begin
            chk1("grant_wait", m_req, 1'b1);
            return;
        end
        for (int i = 0; i < rdy; i++) begin
            tick();
            chk1("req_held", m_req, 1'b1);
            chk("addr_held", m_addr, a);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk1("req_drop", m_req, 1'b0);
        for (int i = 0; i < rv; i++) tick();
        m_rvalid = 1'b1;
        m_rdata  = data;
        tick();
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;
    endtask

    // One full transaction, checked against the model; ends in the done-pulse cycle
    task automatic run_tx(input logic is_mem, input logic is_wr, input logic [31:0] exp_addr,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                          input int exp_lat, input logic other_pending,
                          input int rdy, input int rv, output logic ok);
        logic [31:0] data, a, wd;
        logic        we;
        logic [3:0]  st;
        int          lat;
        data = $urandom;
        serve(data, rdy, rv, lat, a, we, st, wd, ok);
        if (!ok) return;
        chk("grant_latency", 32'(lat), 32'(exp_lat));
        chk("m_addr", a, exp_addr);
        chk1("m_we", we, is_wr);
        chk("m_wstrb", 32'(st), 32'(exp_strb));
        if (is_wr) chk("m_wdata", wd, exp_wd);
        chk1("if_done", if_done, ~is_mem);
        chk1("mem_done", mem_done, is_mem);
        if (is_mem) begin
            if (!is_wr) exp_mem_rdata = data;
        end else begin
            exp_if_rdata = data;
        end
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("mem_rdata", mem_rdata, exp_mem_rdata);
        chk1("done_stall_mem", stall_mem, ~is_mem & other_pending);
        chk1("done_stall_if", stall_if, other_pending);
        last_mem = is_mem;
    endtask

    initial begin
        logic        ok, abort, is_mem, use_if, use_mem, is_wr, also_rd, first_mem, cur;
        logic [31:0] ia, ma, wd;
        logic [3:0]  st;
        int          pat, ntx, rdy, rv;
        vec_t        v;

        // Fetch with fast memory, then a store with three wait states
        vecs[0]  = '{H,A,L,L,L,Z,Z,S0,L,L,Z,     L,L,Z,Z,S0,    L,L,H,L,Z,Z,L};
        vecs[1]  = '{H,A,L,L,L,Z,Z,S0,H,L,Z,     H,L,A,Z,SF,    L,L,H,L,Z,Z,L};
        vecs[2]  = '{H,A,L,L,L,Z,Z,S0,L,H,RD,    L,L,A,Z,SF,    L,L,H,L,Z,Z,L};
        vecs[3]  = '{H,A,L,L,L,Z,Z,S0,L,L,Z,     L,L,A,Z,SF,    H,L,L,L,RD,Z,L};
        vecs[4]  = '{L,Z,L,L,L,Z,Z,S0,L,L,Z,     L,L,A,Z,SF,    L,L,L,L,RD,Z,L};
        vecs[5]  = '{L,Z,L,L,H,SA,SD,S3,L,L,Z,   L,L,A,Z,SF,    L,L,H,H,RD,Z,L};
        vecs[6]  = '{L,Z,L,L,H,SA,SD,S3,L,L,Z,   H,H,SA,SD,S3,  L,L,H,H,RD,Z,L};
        vecs[7]  = '{L,Z,L,L,H,SA,SD,S3,L,L,Z,   H,H,SA,SD,S3,  L,L,H,H,RD,Z,L};
        vecs[8]  = '{L,Z,L,L,H,SA,SD,S3,L,L,Z,   H,H,SA,SD,S3,  L,L,H,H,RD,Z,L};
        vecs[9]  = '{L,Z,L,L,H,SA,SD,S3,H,L,Z,   H,H,SA,SD,S3,  L,L,H,H,RD,Z,L};
        vecs[10] = '{L,Z,L,L,H,SA,SD,S3,L,H,JD,  L,H,SA,SD,S3,  L,L,H,H,RD,Z,L};
        vecs[11] = '{L,Z,L,L,H,SA,SD,S3,L,L,Z,   L,H,SA,SD,S3,  L,H,L,L,RD,Z,L};
        vecs[12] = '{L,Z,L,L,L,Z,Z,S0,L,L,Z,     L,H,SA,SD,S3,  L,L,L,L,RD,Z,L};

        abort = 1'b0;
        do_reset();
        check_reset_vals("reset");

        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            if_req = v.if_req; if_addr = v.if_addr; if_kill = v.if_kill;
            mem_rd = v.mem_rd; mem_wr = v.mem_wr; mem_addr = v.mem_addr;
            mem_wdata = v.mem_wdata; mem_wstrb = v.mem_wstrb;
            m_ready = v.m_ready; m_rvalid = v.m_rvalid; m_rdata = v.m_rdata;
            #1;
            chk1($sformatf("vec%0d_m_req", i), m_req, v.e_m_req);
            chk1($sformatf("vec%0d_m_we", i), m_we, v.e_m_we);
            chk($sformatf("vec%0d_m_addr", i), m_addr, v.e_m_addr);
            if (v.e_m_we) chk($sformatf("vec%0d_m_wdata", i), m_wdata, v.e_m_wdata);
            chk($sformatf("vec%0d_m_wstrb", i), 32'(m_wstrb), 32'(v.e_m_wstrb));
            chk1($sformatf("vec%0d_if_done", i), if_done, v.e_if_done);
            chk1($sformatf("vec%0d_mem_done", i), mem_done, v.e_mem_done);
            chk1($sformatf("vec%0d_stall_if", i), stall_if, v.e_stall_if);
            chk1($sformatf("vec%0d_stall_mem", i), stall_mem, v.e_stall_mem);
            chk($sformatf("vec%0d_if_rdata", i), if_rdata, v.e_if_rdata);
            chk($sformatf("vec%0d_mem_rdata", i), mem_rdata, v.e_mem_rdata);
            chk1($sformatf("vec%0d_err", i), err, v.e_err);
            @(posedge clk);
            #1;
        end

        // Conflict after reset: MEM first, then alternating while both keep asking
        do_reset();
        if_req = 1'b1; if_addr = 32'h300; mem_rd = 1'b1; mem_addr = 32'h400;
        for (int k = 0; k < 4; k++) begin
            is_mem = (k % 2 == 0);
            run_tx(is_mem, 1'b0, is_mem ? 32'h400 : 32'h300, 4'hF, 32'h0,
                   (k == 0) ? 1 : 2, 1'b1, 1, 1, ok);
            if (!ok) break;
        end
        drive_idle();
        tick();

        // Kill: suppressed in IDLE, then discard of an accepted fetch in WAIT
        if_req = 1'b1; if_addr = 32'h500; if_kill = 1'b1;
        tick();
        chk1("kill_idle_1", m_req, 1'b0);
        tick();
        chk1("kill_idle_2", m_req, 1'b0);
        if_kill = 1'b0;
        tick();
        chk1("kill_fetch_req", m_req, 1'b1);
        chk("kill_fetch_addr", m_addr, 32'h500);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        if_kill = 1'b1; if_req = 1'b0; mem_rd = 1'b1; mem_addr = 32'h600;
        tick();
        if_kill = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hBADB_AD00;
        tick();
        m_rvalid = 1'b0; m_rdata = 32'h0;
        chk1("kill_no_if_done", if_done, 1'b0);
        chk1("kill_no_mem_done", mem_done, 1'b0);
        chk1("kill_idle_m_req", m_req, 1'b0);
        chk("kill_if_rdata", if_rdata, exp_if_rdata);
        run_tx(1'b1, 1'b0, 32'h600, 4'hF, 32'h0, 1, 1'b0, 0, 0, ok);
        drive_idle();
        tick();

        // Timeout: memory never accepts; err after four REQ cycles and sticks
        if_req = 1'b1; if_addr = 32'h700;
        tick();
        for (int c = 1; c <= 4; c++) begin
            chk1($sformatf("to_req_c%0d", c), m_req, 1'b1);
            chk1($sformatf("to_err_c%0d", c), err, 1'b0);
            tick();
        end
        chk1("to_err_set", err, 1'b1);
        chk1("to_m_req_off", m_req, 1'b0);
        chk1("to_no_done", if_done, 1'b0);
        if_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk1($sformatf("to_err_sticky%0d", c), err, 1'b1);
            chk1($sformatf("to_no_done%0d", c), if_done, 1'b0);
        end

        // Reset mid-WAIT, then a stale response must be ignored
        if_req = 1'b1; if_addr = 32'h800;
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        rst = 1'b1; if_req = 1'b0;
        tick();
        rst = 1'b0;
        check_reset_vals("rst_mid");
        m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
        tick();
        m_rvalid = 1'b0; m_rdata = 32'h0;
        check_reset_vals("rst_stale");
        tick();
        chk1("rst_stale_if_done", if_done, 1'b0);

        // Randomized transactions against the model
        do_reset();
        for (int it = 0; it < 150 && !abort; it++) begin
            pat     = $urandom_range(0, 2);
            use_if  = (pat != 1);
            use_mem = (pat != 0);
            is_wr   = 1'($urandom_range(0, 1));
            also_rd = 1'($urandom_range(0, 1));
            ia = $urandom; ma = $urandom; wd = $urandom; st = 4'($urandom);
            if_req = use_if; if_addr = ia;
            mem_rd = use_mem & (~is_wr | also_rd);
            mem_wr = use_mem & is_wr;
            mem_addr = ma; mem_wdata = wd; mem_wstrb = st;
            first_mem = use_mem & (~use_if | ~last_mem);
            ntx = (use_if && use_mem) ? 2 : 1;
            for (int k = 0; k < ntx; k++) begin
                cur = (k == 0) ? first_mem : ~first_mem;
                rdy = $urandom_range(0, 2);
                rv  = $urandom_range(0, 2);
                run_tx(cur, cur & is_wr, cur ? ma : ia, (cur & is_wr) ? st : 4'hF, wd,
                       (k == 0) ? 1 : 2, (k == 0) && (ntx == 2), rdy, rv, ok);
                if (!ok) begin
                    abort = 1'b1;
                    break;
                end
                if (cur) begin
                    mem_rd = 1'b0;
                    mem_wr = 1'b0;
                end else begin
                    if_req = 1'b0;
                end
            end
            tick();
            chk1("rand_if_pulse_end", if_done, 1'b0);
            chk1("rand_mem_pulse_end", mem_done, 1'b0);
        end
        chk1("rand_err_clear", err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
